muller_c_array: RTL and testbench
=================================

# muller_c_array

Parametrised, synchronously-emulated Muller C-element array, successor to the single fixed-width C-element project. It provides CHANNELS independent C-elements, each with INPUTS inputs and a per-channel run-time mode: symmetric, asymmetric, majority or hold. It also adds input synchronisation, per-channel transition counters and rise/fall event pulses. It sits between the user-project I/O pins and the formal/cover harness, replacing the single-channel block.

## Interface

Parameters:
- CHANNELS, 2, number of independent C-elements.
- INPUTS, 3, inputs per channel; legal range 2..8.
- SYNC_STAGES, 2, synchroniser flops per input bit; legal range 1..3.
- CNT_W, 8, width of each per-channel transition counter.

Ports:
- clock  in  1  single system clock; all state on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_bits  in  CHANNELS*INPUTS  raw asynchronous inputs; channel c owns bits [c*INPUTS +: INPUTS].
- mode  in  2*CHANNELS  per-channel mode; channel c owns [2c +: 2].
- init_val  in  CHANNELS  per-channel output value loaded at reset; static during reset.
- clear_cnt  in  1  synchronous clear of all counters.
- c_out  out  CHANNELS  C-element outputs, registered.
- rise  out  CHANNELS  one-cycle pulse when c_out goes 0->1.
- fall  out  CHANNELS  one-cycle pulse when c_out goes 1->0.
- toggle_cnt  out  CHANNELS*CNT_W  saturating count of c_out transitions per channel.

## Operation

- Each in_bits bit passes through SYNC_STAGES flops. The last stage is s[i].
- Per-channel evaluation uses s, the current c_out value and the current mode:
  - MODE_SYM (00): if all s are 1, the output becomes 1. If all s are 0, the output becomes 0. Otherwise it holds.
  - MODE_ASYM (01): the output rises when all s are 1. It falls when s[1..INPUTS-1] are all 0; s[0] is a plus-only input and is ignored for falling. Otherwise it holds.
  - MODE_MAJ (10): the output rises when popcount(s) > INPUTS/2 (integer division). It falls when popcount(s) < (INPUTS+1)/2. For even INPUTS, the exact tie holds the current value (hysteresis).
  - MODE_HOLD (11): the output is frozen and no events are produced.
- rise and fall are asserted in the same cycle that c_out takes its new value. They are never asserted together.
- toggle_cnt increments on rise or fall and saturates at 2^CNT_W-1.
- clear_cnt zeroes all counters. A transition in the same cycle as clear_cnt is not counted, so the counter reads 0.
- A mode change takes effect on the next evaluation. c_out is never forced by a mode change.

## Timing

- Reset (reset_n=0 at a clock edge):
  - c_out is set to init_val.
  - Every synchroniser flop of channel c is set to init_val[c], so there is no spurious transition after reset release.
  - rise and fall are set to 0.
  - toggle_cnt is set to 0.
- Reset applied mid-operation overrides everything in that cycle, including clear_cnt and pending transitions.
- Latency: a stable input change is reflected on c_out SYNC_STAGES+1 clock edges later.
- An input pulse shorter than one clock period may be missed. This is acceptable and is not flagged.
- There are no handshakes. All outputs are registered and glitch-free.

## Structure

- Package muller_c_pkg contains:
  - localparams MODE_SYM, MODE_ASYM, MODE_MAJ, MODE_HOLD (2 bits each);
  - a popcount function sized for up to 8 inputs.
- Sub-module muller_c_cell holds one channel: synchroniser, evaluation, c_out register, event pulses and counter. muller_c_array instantiates CHANNELS copies through a generate loop and performs only bus slicing.

## Test plan

- Reset with init_val=2'b10 and in_bits all 0 -> c_out=2'b10 and all counts 0. After release, channel 1 (SYM) falls exactly SYNC_STAGES+1 cycles later: fall[1] pulses once and toggle_cnt[1]=1.
- Channel 0 in SYM mode, in_bits[2:0] stepped 000->011->111->101->000 -> c_out[0] = 0, 0, 1, 1, 0 (each after the latency). Exactly one rise and one fall occur; count=2.
- Channel 0 in ASYM mode, output at 1, inputs set to 001 -> c_out falls, because bit 0 is ignored. Inputs 110 -> c_out holds at 0.
- MAJ mode with INPUTS=4: 0011 from output 0 holds 0; 0111 rises; 0011 holds 1; 0001 falls.
- 300 alternating 000/111 steps with CNT_W=8 -> toggle_cnt saturates at 255. clear_cnt asserted in the same cycle as a transition -> count reads 0 and the pulse is still emitted.
- HOLD mode entered while c_out=1, inputs driven to 000 -> c_out stays 1 with no pulses. Switching to SYM -> it falls on the next evaluation.

Source files
------------

// File: rtl/muller_c_pkg.sv
// Shared mode encodings and helpers for the Muller C-element array.
// Defines the 2-bit per-channel mode values and an 8-input popcount.
package muller_c_pkg;

    localparam logic [1:0] MODE_SYM  = 2'b00;
    localparam logic [1:0] MODE_ASYM = 2'b01;
    localparam logic [1:0] MODE_MAJ  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/muller_c_array_if.sv
// Signal bundle between the user-project pins and the C-element array.
// The master drives the raw inputs and controls; the slave returns the outputs and counters.
interface muller_c_array_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned INPUTS   = 3,
    parameter int unsigned CNT_W    = 8
);
    logic [CHANNELS*INPUTS-1:0] in_bits;
    logic [2*CHANNELS-1:0]      mode;
    logic [CHANNELS-1:0]        init_val;
    logic                       clear_cnt;
    logic [CHANNELS-1:0]        c_out;
    logic [CHANNELS-1:0]        rise;
    logic [CHANNELS-1:0]        fall;
    logic [CHANNELS*CNT_W-1:0]  toggle_cnt;

    modport master (
        output in_bits, mode, init_val, clear_cnt,
        input  c_out, rise, fall, toggle_cnt
    );

    modport slave (
        input  in_bits, mode, init_val, clear_cnt,
        output c_out, rise, fall, toggle_cnt
    );
endinterface

// File: rtl/muller_c_cell.sv
// One C-element channel: input synchroniser, mode-dependent evaluation,
// registered output with rise/fall pulses and a saturating transition counter.
module muller_c_cell
    import muller_c_pkg::*;
#(
    parameter int unsigned INPUTS      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [INPUTS-1:0] in_bits,
    input  logic [1:0]        mode,
    input  logic              init_val,
    input  logic              clear_cnt,
    output logic              c_out,
    output logic              rise,
    output logic              fall,
    output logic [CNT_W-1:0]  toggle_cnt
);

    localparam logic [3:0] RISE_GT = 4'(INPUTS / 2);
    localparam logic [3:0] FALL_LT = 4'((INPUTS + 1) / 2);

    logic [SYNC_STAGES-1:0][INPUTS-1:0] sync_q;
    logic [INPUTS-1:0] s;
    logic [7:0]        s_ext;
    logic [3:0]        ones;
    logic              c_next;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        s_ext = '0;
        s_ext[INPUTS-1:0] = s;
    end

    assign ones = popcount(s_ext);

    always_comb begin
        c_next = c_out;
        case (mode)
            MODE_SYM: begin
                if (&s)       c_next = 1'b1;
                else if (~|s) c_next = 1'b0;
            end
            // s[0] only participates in rising
            MODE_ASYM: begin
                if (&s)                    c_next = 1'b1;
                else if (~|s[INPUTS-1:1])  c_next = 1'b0;
            end
            MODE_MAJ: begin
                if (ones > RISE_GT)      c_next = 1'b1;
                else if (ones < FALL_LT) c_next = 1'b0;
            end
            default: c_next = c_out;
        endcase
    end

    // Synchronisers preload init_val so the first evaluation after reset sees no change
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q     <= {SYNC_STAGES{{INPUTS{init_val}}}};
            c_out      <= init_val;
            rise       <= 1'b0;
            fall       <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            sync_q[0] <= in_bits;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            c_out <= c_next;
            rise  <= c_next & ~c_out;
            fall  <= ~c_next & c_out;
            if (clear_cnt) begin
                toggle_cnt <= '0;
            end else if ((c_next != c_out) && (toggle_cnt != '1)) begin
                toggle_cnt <= toggle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/muller_c_array.sv
// Array of CHANNELS independent Muller C-element cells.
// Only slices the interface buses onto the per-channel cells.
module muller_c_array
    import muller_c_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned INPUTS      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input logic            clock,
    input logic            reset_n,
    muller_c_array_if.slave bus
);

    logic [CHANNELS-1:0]       c_out_w;
    logic [CHANNELS-1:0]       rise_w;
    logic [CHANNELS-1:0]       fall_w;
    logic [CHANNELS*CNT_W-1:0] cnt_w;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        muller_c_cell #(
            .INPUTS      (INPUTS),
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_cell (
            .clock      (clock),
            .reset_n    (reset_n),
            .in_bits    (bus.in_bits[c*INPUTS +: INPUTS]),
            .mode       (bus.mode[2*c +: 2]),
            .init_val   (bus.init_val[c]),
            .clear_cnt  (bus.clear_cnt),
            .c_out      (c_out_w[c]),
            .rise       (rise_w[c]),
            .fall       (fall_w[c]),
            .toggle_cnt (cnt_w[c*CNT_W +: CNT_W])
        );
    end

    assign bus.c_out      = c_out_w;
    assign bus.rise       = rise_w;
    assign bus.fall       = fall_w;
    assign bus.toggle_cnt = cnt_w;

endmodule

// File: tb/tb_muller_c_array.sv
// Bench for muller_c_array: a 3-input and a 4-input array checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_muller_c_array;

    localparam int SYNC = 2;
    localparam int CMAX = 255;

    logic clock;
    logic reset_n;

    muller_c_array_if #(.CHANNELS(2), .INPUTS(3), .CNT_W(8)) bus3 ();
    muller_c_array_if #(.CHANNELS(2), .INPUTS(4), .CNT_W(8)) bus4 ();

    muller_c_array #(.CHANNELS(2), .INPUTS(3), .SYNC_STAGES(SYNC), .CNT_W(8)) u_dut3 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus3.slave)
    );

    muller_c_array #(.CHANNELS(2), .INPUTS(4), .SYNC_STAGES(SYNC), .CNT_W(8)) u_dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Behavioural model: inputs seen SYNC edges ago decide the next output
    int m_pipe [2][2][SYNC];
    int m_out  [2][2];
    int m_rise [2][2];
    int m_fall [2][2];
    int m_cnt  [2][2];
    bit m_valid = 1'b0;

    function automatic int count_ones(input int v, input int n);
        int k = 0;
        for (int i = 0; i < n; i++) k += (v >> i) & 1;
        return k;
    endfunction

    function automatic int decide(input int s, input int n, input int md, input int cur);
        int full = (1 << n) - 1;
        int k = count_ones(s, n);
        case (md)
            0: begin
                if (s == full) return 1;
                if (s == 0) return 0;
            end
            1: begin
                if (s == full) return 1;
                if ((s >> 1) == 0) return 0;
            end
            2: begin
                if (k > n / 2) return 1;
                if (k < (n + 1) / 2) return 0;
            end
            default: ;
        endcase
        return cur;
    endfunction

    task automatic model_step(input int d, input int n, input int inb, input int md,
                              input int init, input int rstn, input int clr);
        for (int c = 0; c < 2; c++) begin
            int x   = (inb >> (c * n)) & ((1 << n) - 1);
            int m   = (md >> (2 * c)) & 3;
            int iv  = (init >> c) & 1;
            int nxt;
            if (rstn == 0) begin
                for (int st = 0; st < SYNC; st++) m_pipe[d][c][st] = iv ? ((1 << n) - 1) : 0;
                m_out[d][c]  = iv;
                m_rise[d][c] = 0;
                m_fall[d][c] = 0;
                m_cnt[d][c]  = 0;
            end else begin
                nxt = decide(m_pipe[d][c][SYNC-1], n, m, m_out[d][c]);
                m_rise[d][c] = (nxt == 1 && m_out[d][c] == 0) ? 1 : 0;
                m_fall[d][c] = (nxt == 0 && m_out[d][c] == 1) ? 1 : 0;
                if (clr != 0) m_cnt[d][c] = 0;
                else if (nxt != m_out[d][c] && m_cnt[d][c] < CMAX) m_cnt[d][c]++;
                m_out[d][c] = nxt;
                for (int st = SYNC - 1; st > 0; st--) m_pipe[d][c][st] = m_pipe[d][c][st-1];
                m_pipe[d][c][0] = x;
            end
        end
    endtask

    always @(posedge clock) begin
        model_step(0, 3, int'(bus3.in_bits), int'(bus3.mode), int'(bus3.init_val),
                   int'(reset_n), int'(bus3.clear_cnt));
        model_step(1, 4, int'(bus4.in_bits), int'(bus4.mode), int'(bus4.init_val),
                   int'(reset_n), int'(bus4.clear_cnt));
        if (!reset_n) m_valid = 1'b1;
    end

    task automatic cmp_dut(input int d, input logic [1:0] co, input logic [1:0] ri,
                           input logic [1:0] fa, input logic [31:0] tc);
        chk($sformatf("d%0d_c_out", d), 32'(co), 32'(m_out[d][0] | (m_out[d][1] << 1)));
        chk($sformatf("d%0d_rise", d), 32'(ri), 32'(m_rise[d][0] | (m_rise[d][1] << 1)));
        chk($sformatf("d%0d_fall", d), 32'(fa), 32'(m_fall[d][0] | (m_fall[d][1] << 1)));
        chk($sformatf("d%0d_cnt", d), tc, 32'(m_cnt[d][0] | (m_cnt[d][1] << 8)));
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            cmp_dut(0, bus3.c_out, bus3.rise, bus3.fall, 32'(bus3.toggle_cnt));
            cmp_dut(1, bus4.c_out, bus4.rise, bus4.fall, 32'(bus4.toggle_cnt));
        end
    end

    initial begin
        reset_n        = 1'b0;
        bus3.in_bits   = '0;
        bus3.mode      = 4'b0000;
        bus3.init_val  = 2'b10;
        bus3.clear_cnt = 1'b0;
        bus4.in_bits   = '0;
        bus4.mode      = 4'b1010;
        bus4.init_val  = 2'b00;
        bus4.clear_cnt = 1'b0;

        // Reset state and the first post-reset fall on channel 1
        cyc(2);
        chk("rst_c_out", 32'(bus3.c_out), 32'h2);
        chk("rst_cnt", 32'(bus3.toggle_cnt), 32'h0);
        chk("rst_pulses", 32'({bus3.rise, bus3.fall}), 32'h0);
        reset_n = 1'b1;
        cyc(1);
        chk("post_rst_e1", 32'({bus3.c_out[1], bus3.fall[1]}), 32'h2);
        cyc(1);
        chk("post_rst_e2", 32'({bus3.c_out[1], bus3.fall[1]}), 32'h2);
        cyc(1);
        chk("post_rst_fall", 32'({bus3.c_out[1], bus3.fall[1]}), 32'h1);
        chk("post_rst_cnt1", 32'(bus3.toggle_cnt[15:8]), 32'd1);
        cyc(1);
        chk("post_rst_fall_end", 32'(bus3.fall[1]), 32'h0);

        // Symmetric sequence on channel 0
        bus3.in_bits[2:0] = 3'b000; cyc(3); chk("sym_000", 32'(bus3.c_out[0]), 32'd0);
        bus3.in_bits[2:0] = 3'b011; cyc(3); chk("sym_011", 32'(bus3.c_out[0]), 32'd0);
        bus3.in_bits[2:0] = 3'b111; cyc(3); chk("sym_111", 32'({bus3.c_out[0], bus3.rise[0]}), 32'h3);
        bus3.in_bits[2:0] = 3'b101; cyc(3); chk("sym_101", 32'(bus3.c_out[0]), 32'd1);
        bus3.in_bits[2:0] = 3'b000; cyc(3); chk("sym_000b", 32'({bus3.c_out[0], bus3.fall[0]}), 32'h1);
        chk("sym_cnt0", 32'(bus3.toggle_cnt[7:0]), 32'd2);

        // Asymmetric: bit 0 is ignored for falling
        bus3.in_bits[2:0] = 3'b111; cyc(3); chk("asym_setup", 32'(bus3.c_out[0]), 32'd1);
        bus3.mode[1:0] = 2'b01;
        bus3.in_bits[2:0] = 3'b001; cyc(3); chk("asym_001", 32'({bus3.c_out[0], bus3.fall[0]}), 32'h1);
        bus3.in_bits[2:0] = 3'b110; cyc(3); chk("asym_110", 32'(bus3.c_out[0]), 32'd0);

        // Majority with 4 inputs, tie holds
        bus4.in_bits[3:0] = 4'b0011; cyc(3); chk("maj_0011_lo", 32'(bus4.c_out[0]), 32'd0);
        bus4.in_bits[3:0] = 4'b0111; cyc(3); chk("maj_0111", 32'(bus4.c_out[0]), 32'd1);
        bus4.in_bits[3:0] = 4'b0011; cyc(3); chk("maj_0011_hi", 32'(bus4.c_out[0]), 32'd1);
        bus4.in_bits[3:0] = 4'b0001; cyc(3); chk("maj_0001", 32'(bus4.c_out[0]), 32'd0);

        // Counter saturation on channel 1, then clear coinciding with a transition
        for (int i = 0; i < 300; i++) begin
            bus3.in_bits[5:3] = (i % 2 == 0) ? 3'b111 : 3'b000;
            cyc(3);
        end
        chk("sat_cnt1", 32'(bus3.toggle_cnt[15:8]), 32'd255);
        chk("sat_c_out1", 32'(bus3.c_out[1]), 32'd0);
        bus3.in_bits[5:3] = 3'b111;
        cyc(2);
        bus3.clear_cnt = 1'b1;
        cyc(1);
        bus3.clear_cnt = 1'b0;
        chk("clr_cnt1", 32'(bus3.toggle_cnt[15:8]), 32'd0);
        chk("clr_cnt0", 32'(bus3.toggle_cnt[7:0]), 32'd0);
        chk("clr_rise1", 32'({bus3.c_out[1], bus3.rise[1]}), 32'h3);

        // Hold freezes the output; returning to symmetric releases it
        bus3.mode[3:2] = 2'b11;
        bus3.in_bits[5:3] = 3'b000;
        cyc(5);
        chk("hold_c_out1", 32'({bus3.c_out[1], bus3.fall[1]}), 32'h2);
        bus3.mode[3:2] = 2'b00;
        cyc(1);
        chk("hold_release", 32'({bus3.c_out[1], bus3.fall[1]}), 32'h1);

        // Mid-operation reset overrides a pending clear and loads new init values
        cyc(2);
        bus3.init_val  = 2'b01;
        bus4.init_val  = 2'b10;
        bus3.clear_cnt = 1'b1;
        reset_n        = 1'b0;
        cyc(1);
        chk("mid_rst_c3", 32'(bus3.c_out), 32'h1);
        chk("mid_rst_c4", 32'(bus4.c_out), 32'h2);
        chk("mid_rst_cnt", 32'(bus3.toggle_cnt), 32'h0);
        reset_n        = 1'b1;
        bus3.clear_cnt = 1'b0;
        cyc(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
